serial_word_loader: RTL and testbench

Upstream feeder for the 32-bit gated-latch data register. It deserializes a framed serial bit stream into a WIDTH-bit word. It presents the word on the register's D bus and issues a single-cycle load strobe on the register's enable once the word is complete. Outside that strobe, the word is held stable so the level-sensitive register never captures a partial value.

---
 rtl/serial_word_loader.sv | 135 +++++++++++++
 tb/tb_serial_word_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// Deserializes a framed serial stream into a WIDTH-bit word and strobes load_en
// for one cycle once the word is complete; the word is held stable otherwise.
module serial_word_loader #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   sin,
    input  logic                   sin_valid,
    output logic [WIDTH-1:0]       word,
    output logic                   load_en,
    output logic                   busy,
    output logic [$clog2(WIDTH):0] bit_count,
    output logic                   overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             load_en_q, load_en_d;
    logic             busy_q, busy_d;

    // State and output registers; outputs are derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            ovr_q     <= 1'b0;
            load_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            load_en_q <= load_en_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; abort beats a simultaneous final bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sin_valid && (cnt_q == CW'(WIDTH - 1))) begin
                    state_d = LOAD;
                end else begin
                    state_d = SHIFT;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        word_d    = word_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        load_en_d = (state_d == LOAD);
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    word_d = {WIDTH{1'b0}};
                    cnt_d  = {CW{1'b0}};
                    ovr_d  = 1'b0;
                end else begin
                    word_d = word_q;
                end
            end
            SHIFT: begin
                if (start) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                // An aborted frame keeps its partial word so D stays quiet.
                if (abort) begin
                    cnt_d = {CW{1'b0}};
                end else if (sin_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (MSB_FIRST) begin
                        word_d = {word_q[WIDTH-2:0], sin};
                    end else begin
                        word_d = {sin, word_q[WIDTH-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            LOAD: begin
                if (start) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
            end
            default: begin
                word_d = word_q;
            end
        endcase
    end

    assign word      = word_q;
    assign load_en   = load_en_q;
    assign busy      = busy_q;
    assign bit_count = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench: one MSB-first and one LSB-first loader share the same stream,
// each feeding a level-sensitive register model.
module tb_serial_word_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sin = 1'b0;
    logic sin_valid = 1'b0;

    logic [31:0] word_m, word_l;
    logic        load_en_m, load_en_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [5:0]  cnt_m, cnt_l;

    logic [31:0] reg_m = 32'h0;
    logic [31:0] reg_l = 32'h0;
    int          n_load_m = 0;
    int          n_load_l = 0;
    int          n_chk = 0;
    int          n_err = 0;

    serial_word_loader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sin(sin),
        .sin_valid(sin_valid), .word(word_m), .load_en(load_en_m), .busy(busy_m),
        .bit_count(cnt_m), .overrun(ovr_m)
    );

    serial_word_loader #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sin(sin),
        .sin_valid(sin_valid), .word(word_l), .load_en(load_en_l), .busy(busy_l),
        .bit_count(cnt_l), .overrun(ovr_l)
    );

    always #5 clk = ~clk;

    // Gated-latch data registers downstream of each loader.
    always @(load_en_m or word_m) if (load_en_m) reg_m = word_m;
    always @(load_en_l or word_l) if (load_en_l) reg_l = word_l;

    always @(posedge load_en_m) n_load_m++;
    always @(posedge load_en_l) n_load_l++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ld, input logic bsy,
                             input logic [5:0] cnt, input logic ov);
        chk({tag, ".load_en_m"}, {31'd0, load_en_m}, {31'd0, ld});
        chk({tag, ".load_en_l"}, {31'd0, load_en_l}, {31'd0, ld});
        chk({tag, ".busy_m"}, {31'd0, busy_m}, {31'd0, bsy});
        chk({tag, ".busy_l"}, {31'd0, busy_l}, {31'd0, bsy});
        chk({tag, ".cnt_m"}, {26'd0, cnt_m}, {26'd0, cnt});
        chk({tag, ".cnt_l"}, {26'd0, cnt_l}, {26'd0, cnt});
        chk({tag, ".ovr_m"}, {31'd0, ovr_m}, {31'd0, ov});
        chk({tag, ".ovr_l"}, {31'd0, ovr_l}, {31'd0, ov});
    endtask

    task automatic chk_words(input string tag, input logic [31:0] em, input logic [31:0] el);
        chk({tag, ".word_m"}, word_m, em);
        chk({tag, ".word_l"}, word_l, el);
    endtask

    // Accepted start; sin_valid in the start cycle must be ignored.
    task automatic start_frame();
        start = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        start = 1'b0; sin_valid = 1'b0;
        chk_state("start", 1'b0, 1'b1, 6'd0, 1'b0);
        chk_words("clear", 32'h0, 32'h0);
    endtask

    // s[31] is sent first; em/el are the expected words of each loader.
    task automatic frame(input logic [31:0] s, input logic [31:0] em, input logic [31:0] el,
                         input bit gap, input bit ovr);
        start_frame();
        for (int i = 0; i < 32; i++) begin
            sin = s[31-i]; sin_valid = 1'b1; start = ovr && (i == 5);
            tick();
            start = 1'b0;
            chk_state("shift", (i == 31), 1'b1, 6'(i + 1), ovr && (i >= 5));
            if (gap && i < 31) begin
                sin = ~sin; sin_valid = 1'b0;
                tick();
                chk_state("gap", 1'b0, 1'b1, 6'(i + 1), ovr && (i >= 5));
            end
        end
        chk_words("load", em, el);
        sin_valid = 1'b0; start = ovr;
        tick();
        start = 1'b0;
        chk_state("done", 1'b0, 1'b0, 6'd32, ovr);
        chk_words("hold", em, el);
        chk("reg_m", reg_m, em);
        chk("reg_l", reg_l, el);
    endtask

    task automatic abort_test(input int n, input logic [31:0] em, input logic [31:0] el,
                              input logic [31:0] rm, input logic [31:0] rl);
        start_frame();
        for (int i = 0; i < n; i++) begin
            sin = 1'b1; sin_valid = 1'b1;
            tick();
        end
        abort = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        tick();
        abort = 1'b0; sin_valid = 1'b0;
        chk_state("abort", 1'b0, 1'b0, 6'd0, 1'b0);
        chk_words("partial", em, el);
        tick();
        chk_state("post_abort", 1'b0, 1'b0, 6'd0, 1'b0);
        chk("abort.reg_m", reg_m, rm);
        chk("abort.reg_l", reg_l, rl);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) begin
            tick();
            chk_state("reset", 1'b0, 1'b0, 6'd0, 1'b0);
            chk_words("reset", 32'h0, 32'h0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk_state("idle", 1'b0, 1'b0, 6'd0, 1'b0);
            chk_words("idle", 32'h0, 32'h0);
        end

        frame(32'h8000_0801, 32'h8000_0801, 32'h8010_0001, 1'b0, 1'b0);
        frame(32'h5555_5555, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 1'b0);

        abort_test(10, 32'h0000_03FF, 32'hFFC0_0000, 32'h5555_5555, 32'hAAAA_AAAA);
        abort_test(31, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h5555_5555, 32'hAAAA_AAAA);

        // Abort in IDLE blocks a simultaneous start.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_state("idle_abort", 1'b0, 1'b0, 6'd0, 1'b0);

        frame(32'h4007_FE05, 32'h4007_FE05, 32'hA07F_E002, 1'b0, 1'b0);
        frame(32'h1234_5678, 32'h1234_5678, 32'h1E6A_2C48, 1'b0, 1'b1);

        // start_frame checks overrun is cleared by the accepted start.
        start_frame();
        for (int i = 0; i < 20; i++) begin
            sin = i[0]; sin_valid = 1'b1;
            tick();
        end
        chk_state("pre_rst", 1'b0, 1'b1, 6'd20, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 1'b0, 6'd0, 1'b0);
        chk_words("async_rst", 32'h0, 32'h0);
        sin_valid = 1'b0;
        repeat (2) begin
            tick();
            chk_state("rst_hold", 1'b0, 1'b0, 6'd0, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk_state("rst_release", 1'b0, 1'b0, 6'd0, 1'b0);

        chk("n_load_m", n_load_m, 32'd4);
        chk("n_load_l", n_load_l, 32'd4);
        chk("final.reg_m", reg_m, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
